// File: rtl/alu_types.sv
// ALU command encoding shared by the execute stage and the ALU.
// ADD must stay at encoding 0: it is the idle/reset command on alu_cmd.
// Encodings not listed here are legal and are passed through to the ALU untouched.
package alu_types;
  typedef enum logic [3:0] {
    ADD = 4'h0,
    SUB = 4'h1,
    AND = 4'h2,
    OR  = 4'h3,
    XOR = 4'h4,
    NOT = 4'h5,
    INC = 4'h6,
    DEC = 4'h7,
    SHL = 4'h8,
    SHR = 4'h9
  } cmd_t;
endpackage

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: issue/execute/writeback wrapper around an external ALU.
//   - NREGS x 32 register file, r0 reads as zero and ignores writes.
//   - in_*    : decoded instruction, valid/ready handshake.
//   - load_*  : host register write port, has priority over issue.
//   - alu_*   : operands/command out of the EX register, result/flags back in.
//   - wb_*    : one-cycle writeback report, flags = {V,C,N,Z} of last op.
//   - dbg_*   : combinational regfile peek (no forwarding).
module alu_exec_stage
  import alu_types::*;
#(
  parameter int NREGS = 8,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  cmd_t          in_cmd,
  input  logic [AW-1:0] in_rd,
  input  logic [AW-1:0] in_ra,
  input  logic [AW-1:0] in_rb,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data,
  output cmd_t          alu_cmd,
  output logic [31:0]   alu_a,
  output logic [31:0]   alu_b,
  input  logic [31:0]   alu_data,
  input  logic          alu_v,
  input  logic          alu_c,
  input  logic          alu_n,
  input  logic          alu_z,
  output logic          wb_valid,
  output logic [AW-1:0] wb_rd,
  output logic [31:0]   wb_data,
  output logic [3:0]    flags,
  input  logic [AW-1:0] dbg_addr,
  output logic [31:0]   dbg_data
);

  logic [NREGS-1:0][31:0] rf_q, rf_d;

  logic          ex_valid_q, ex_valid_d;
  cmd_t          ex_cmd_q,   ex_cmd_d;
  logic [AW-1:0] ex_rd_q,    ex_rd_d;
  logic [31:0]   ex_a_q,     ex_a_d;
  logic [31:0]   ex_b_q,     ex_b_d;

  logic          wb_valid_q, wb_valid_d;
  logic [AW-1:0] wb_rd_q,    wb_rd_d;
  logic [31:0]   wb_data_q,  wb_data_d;
  logic [3:0]    flags_q,    flags_d;

  logic accept;
  logic fwd_a, fwd_b;

  // Load wins over issue; a load additionally waits for EX to empty so a
  // load write and a writeback never land on the same edge.
  assign in_ready   = !reset && !load_valid;
  assign load_ready = load_valid && !ex_valid_q && !reset;
  assign accept     = in_valid && in_ready;

  // The instruction in EX writes back on the same edge the new one issues,
  // so a dependent operand is taken straight from the ALU result.
  assign fwd_a = ex_valid_q && (ex_rd_q != '0) && (in_ra == ex_rd_q);
  assign fwd_b = ex_valid_q && (ex_rd_q != '0) && (in_rb == ex_rd_q);

  always_comb begin
    rf_d       = rf_q;
    ex_valid_d = accept;
    ex_cmd_d   = ex_cmd_q;
    ex_rd_d    = ex_rd_q;
    ex_a_d     = ex_a_q;
    ex_b_d     = ex_b_q;
    wb_valid_d = ex_valid_q;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    flags_d    = flags_q;

    if (accept) begin
      ex_cmd_d = in_cmd;
      ex_rd_d  = in_rd;
      ex_a_d   = fwd_a ? alu_data : rf_q[in_ra];
      ex_b_d   = fwd_b ? alu_data : rf_q[in_rb];
    end

    if (ex_valid_q) begin
      if (ex_rd_q != '0) rf_d[ex_rd_q] = alu_data;
      flags_d   = {alu_v, alu_c, alu_n, alu_z};
      wb_rd_d   = ex_rd_q;
      wb_data_d = alu_data;
    end

    // Mutually exclusive with the writeback above (load_ready needs !ex_valid_q).
    if (load_ready && (load_addr != '0)) rf_d[load_addr] = load_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_q       <= '0;
      ex_valid_q <= 1'b0;
      ex_cmd_q   <= ADD;
      ex_rd_q    <= '0;
      ex_a_q     <= '0;
      ex_b_q     <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      flags_q    <= '0;
    end else begin
      rf_q       <= rf_d;
      ex_valid_q <= ex_valid_d;
      ex_cmd_q   <= ex_cmd_d;
      ex_rd_q    <= ex_rd_d;
      ex_a_q     <= ex_a_d;
      ex_b_q     <= ex_b_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      flags_q    <= flags_d;
    end
  end

  assign alu_cmd  = ex_cmd_q;
  assign alu_a    = ex_a_q;
  assign alu_b    = ex_b_q;
  assign wb_valid = wb_valid_q;
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;
  assign flags    = flags_q;
  // r0 is never written and resets to 0, so a plain read returns zero.
  assign dbg_data = rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: behavioural ALU on the alu_* ports, directed
// instructions with hand-computed results pushed to a scoreboard queue, and a
// negedge monitor that pops/compares every writeback (data, rd, flags, cycle).
module tb_alu_exec_stage;
  import alu_types::*;

  logic        clk, reset;
  logic        in_valid, in_ready;
  cmd_t        in_cmd;
  logic [2:0]  in_rd, in_ra, in_rb;
  logic        load_valid, load_ready;
  logic [2:0]  load_addr;
  logic [31:0] load_data;
  cmd_t        alu_cmd;
  logic [31:0] alu_a, alu_b, alu_data;
  logic        alu_v, alu_c, alu_n, alu_z;
  logic        wb_valid;
  logic [2:0]  wb_rd;
  logic [31:0] wb_data;
  logic [3:0]  flags;
  logic [2:0]  dbg_addr;
  logic [31:0] dbg_data;

  alu_exec_stage #(.NREGS(8)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd),
    .in_rd(in_rd), .in_ra(in_ra), .in_rb(in_rb),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_addr(load_addr), .load_data(load_data),
    .alu_cmd(alu_cmd), .alu_a(alu_a), .alu_b(alu_b),
    .alu_data(alu_data), .alu_v(alu_v), .alu_c(alu_c), .alu_n(alu_n), .alu_z(alu_z),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .flags(flags),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // External ALU. C on SUB is the borrow (a < b unsigned).
  logic [32:0] r33;
  always @* begin
    r33   = '0;
    alu_v = 1'b0;
    case (alu_cmd)
      ADD: begin
        r33   = {1'b0, alu_a} + {1'b0, alu_b};
        alu_v = (alu_a[31] == alu_b[31]) && (r33[31] != alu_a[31]);
      end
      SUB: begin
        r33   = {1'b0, alu_a} - {1'b0, alu_b};
        alu_v = (alu_a[31] != alu_b[31]) && (r33[31] != alu_a[31]);
      end
      NOT: r33 = {1'b0, ~alu_a};
      INC: begin
        r33   = {1'b0, alu_a} + 33'd1;
        alu_v = !alu_a[31] && r33[31];
      end
      default: r33 = {1'b0, alu_a};
    endcase
    alu_data = r33[31:0];
    alu_c    = r33[32];
    alu_n    = r33[31];
    alu_z    = (r33[31:0] == 32'd0);
  end

  typedef struct {
    logic [2:0]  rd;
    logic [31:0] data;
    logic [3:0]  flg;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (wb_valid) begin
      if (exp_q.size() == 0) begin
        chk("wb_unexpected", {29'd0, wb_rd}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wb_rd",    {29'd0, wb_rd}, {29'd0, e.rd});
        chk("wb_data",  wb_data, e.data);
        chk("wb_flags", {28'd0, flags}, {28'd0, e.flg});
        chk("wb_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [2:0] a, input logic [31:0] d);
    load_valid = 1'b1; load_addr = a; load_data = d;
    tick();
    load_valid = 1'b0;
  endtask

  // Presents one instruction for exactly one edge; in_ready is high in every
  // use. Writeback is expected visible two edges after this call's start cycle.
  task automatic issue(input cmd_t c, input logic [2:0] rd, input logic [2:0] ra,
                       input logic [2:0] rb, input bit push,
                       input logic [31:0] d, input logic [3:0] f);
    exp_t e;
    in_valid = 1'b1; in_cmd = c; in_rd = rd; in_ra = ra; in_rb = rb;
    if (push) begin
      e.rd = rd; e.data = d; e.flg = f; e.cyc = cyc + 2;
      exp_q.push_back(e);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic dbg(input string name, input logic [2:0] a, input logic [31:0] req);
    dbg_addr = a;
    #1;
    chk(name, dbg_data, req);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_cmd = ADD; in_rd = '0; in_ra = '0; in_rb = '0;
    load_valid = 1'b0; load_addr = '0; load_data = '0; dbg_addr = '0;
    repeat (2) tick();
    reset = 1'b0;
    #1;

    // Reset state
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_load_ready", {31'd0, load_ready}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_flags", {28'd0, flags}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_alu_cmd", {28'd0, alu_cmd}, {28'd0, ADD});
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    for (int i = 0; i < 8; i++) dbg("rst_dbg", i[2:0], 32'd0);

    // Host loads, including a dropped write to r0
    load(3'd1, 32'd5);
    load(3'd2, 32'd3);
    load(3'd0, 32'h1234);
    dbg("load_r1", 3'd1, 32'd5);
    dbg("load_r2", 3'd2, 32'd3);
    dbg("load_r0_dropped", 3'd0, 32'd0);
    chk("load_flags_kept", {28'd0, flags}, 32'd0);

    // ADD r3 = r1 + r2
    issue(ADD, 3'd3, 3'd1, 3'd2, 1'b1, 32'd8, 4'b0000);
    repeat (2) tick();
    dbg("add_r3", 3'd3, 32'd8);

    // Back-to-back dependent SUBs, second forwards r4
    issue(SUB, 3'd4, 3'd1, 3'd2, 1'b1, 32'd2, 4'b0000);
    issue(SUB, 3'd5, 3'd4, 3'd1, 1'b1, 32'hFFFF_FFFD, 4'b0110);
    repeat (2) tick();
    dbg("sub_r4", 3'd4, 32'd2);
    dbg("sub_r5", 3'd5, 32'hFFFF_FFFD);
    chk("sub_flags_hold", {28'd0, flags}, 32'b0110);

    // Writeback to r0 is reported but dropped
    issue(ADD, 3'd0, 3'd1, 3'd2, 1'b1, 32'd8, 4'b0000);
    repeat (2) tick();
    dbg("r0_still_zero", 3'd0, 32'd0);
    issue(NOT, 3'd6, 3'd0, 3'd0, 1'b1, 32'hFFFF_FFFF, 4'b0010);
    repeat (2) tick();
    dbg("not_r6", 3'd6, 32'hFFFF_FFFF);

    // Load while an instruction sits in EX
    issue(ADD, 3'd3, 3'd1, 3'd1, 1'b1, 32'd10, 4'b0000);
    load_valid = 1'b1; load_addr = 3'd7; load_data = 32'hA5;
    #1;
    chk("conf_load_ready_lo", {31'd0, load_ready}, 32'd0);
    chk("conf_in_ready_lo", {31'd0, in_ready}, 32'd0);
    tick();
    chk("conf_load_ready_hi", {31'd0, load_ready}, 32'd1);
    tick();
    load_valid = 1'b0;
    dbg("conf_r7", 3'd7, 32'hA5);
    dbg("conf_r3", 3'd3, 32'd10);

    // Reset right after acceptance kills the instruction
    issue(INC, 3'd1, 3'd1, 3'd0, 1'b0, 32'd0, 4'b0000);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    dbg("rstmid_r1", 3'd1, 32'd0);
    dbg("rstmid_r7", 3'd7, 32'd0);
    chk("rstmid_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rstmid_flags", {28'd0, flags}, 32'd0);

    // All expected writebacks must have been seen
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute/writeback stage that sits directly upstream and downstream of the ALU.
- Owns an 8x32 register file and accepts decoded ALU instructions over a valid/ready handshake.
- Registers operands and drives them to the ALU, then captures the ALU result and V/C/N/Z flags. Writes the result back to the register file and a flags register.
- Provides operand forwarding, plus a host load port for initialising registers.

Parameters:
- NREGS, 8, number of 32-bit registers; power of two, minimum 2.
- AW, $clog2(NREGS), register address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  instruction present
- in_ready  out  1  stage can accept an instruction this cycle
- in_cmd  in  alu_types::cmd_t  ALU operation
- in_rd  in  AW  destination register
- in_ra  in  AW  operand A register
- in_rb  in  AW  operand B register
- load_valid  in  1  host register write request
- load_ready  out  1  host write accepted this cycle
- load_addr  in  AW  host write address
- load_data  in  32  host write data
- alu_cmd  out  alu_types::cmd_t  to ALU cmd
- alu_a  out  32  to ALU A
- alu_b  out  32  to ALU B
- alu_data  in  32  from ALU data
- alu_v, alu_c, alu_n, alu_z  in  1 each  from ALU flags
- wb_valid  out  1  one-cycle pulse: writeback occurred last edge
- wb_rd  out  AW  register written
- wb_data  out  32  value written
- flags  out  4  {V,C,N,Z} of last completed instruction
- dbg_addr  in  AW  debug read address
- dbg_data  out  32  combinational read of regfile[dbg_addr]

Behaviour:
- Reset:
  - All registers cleared to 0.
  - ex_valid, wb_valid and flags = 0.
  - wb_rd = 0, wb_data = 0, alu_cmd = ADD, alu_a = alu_b = 0.
  - Reset mid-instruction discards the in-flight instruction; no writeback occurs.
- Register 0 is hardwired to zero. Writes to it from writeback or load are dropped; reads return 0.
- Pipeline state: EX register {ex_valid, cmd, rd, a, b}. alu_cmd, alu_a and alu_b are driven directly from the EX register.
- Accept rule: in_ready = !reset && !load_valid. Loads have priority over issue. An instruction is accepted on the edge where in_valid && in_ready.
- Issue (edge t):
  - Operands are read and loaded into EX.
  - ex_valid is set to 1 if an instruction was accepted, otherwise cleared.
- Execute/writeback (edge t+1, when ex_valid):
  - regfile[ex.rd] <= alu_data (unless rd=0).
  - flags <= {alu_v, alu_c, alu_n, alu_z}.
  - wb_valid = 1, with wb_rd and wb_data set, during the cycle after t+1.
- Latency: 2 edges from acceptance to regfile/flags update. Throughput is 1 instruction/cycle.
- Forwarding:
  - If ex_valid and ex.rd != 0 and in_ra == ex.rd, operand A comes from alu_data instead of the regfile. Same rule for in_rb.
  - Back-to-back dependent instructions therefore need no stall.
- Load handshake: load_ready = load_valid && !ex_valid && !reset. The write happens on the edge where load_ready is high.
  - A load never collides with a writeback.
  - A pending load blocks issue, so the EX stage drains within 1 cycle.
- Flags hold their value between instructions. Loads never alter flags.
- dbg_data is a purely combinational read and does not see the forwarding path.
- Unknown cmd values pass through to the ALU unchanged. The stage writes back whatever the ALU returns.

Test Plan:
- Reset with load_valid=0 and in_valid=0 -> wb_valid=0, flags=0, dbg_data=0 for all addresses, in_ready=1.
- Load r1=5, r2=3, then issue ADD rd=3 ra=1 rb=2 -> wb_valid pulses 2 edges after acceptance with wb_rd=3, wb_data=8, flags=0000. dbg r3=8.
- Forwarding: issue SUB r4=r1-r2, then next cycle SUB r5=r4-r1 -> r4=2, then r5=0xFFFFFFFD. Flags after the second op have N=1, C equal to the ALU borrow output, Z=0. No bubble.
- Zero register: issue ADD rd=0 with r1=5, r2=3 -> wb_valid=1, dbg r0=0, flags reflect result 8 (Z=0). Then issue NOT rd=6 ra=0 -> r6=0xFFFFFFFF, N=1.
- Load/issue conflict: assert load_valid (addr 7, data 0xA5) while an instruction is in EX -> load_ready=0 for that cycle and in_ready=0. On the next cycle load_ready=1 and r7=0xA5. The in-flight result is written back intact.
- Reset asserted on the cycle after acceptance of INC r1 -> no writeback, r1=0, wb_valid stays 0.
